keypad_scanner: RTL

Scans a 4x4 active-low matrix keypad on the FPGA board and delivers debounced hex key codes to the demo datapath. It is the input-side counterpart of the multiplexed seven-segment display path. It strobes keypad columns with a rotating one-low pattern, the same scanning scheme used on the display anodes, and reads the rows. Each key press, after debouncing, is reported once as a one-cycle pulse, and its code is shifted into a 16-bit entry register that feeds the display selector.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/scan_tick_gen.sv | 27 ++
 rtl/keypad_scanner.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and constants for the keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } scan_state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_class_t;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam int KEY_W = 4;

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running divider, tick high on the last count of each period
module scan_tick_gen #(
   parameter int SCAN_DIV = 100000
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, frame classification, debounce and digit history
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_held,
   output logic [15:0]      digits
);

   localparam int FW = ($clog2(DEBOUNCE_SCANS + 1) > 3) ? $clog2(DEBOUNCE_SCANS + 1) : 3;
   localparam logic [FW-1:0] FCNT_DONE = FW'(DEBOUNCE_SCANS);

   logic [3:0]       row_meta;
   logic [3:0]       row_s;
   logic             tick;
   logic [1:0]       col_idx;
   logic [1:0]       acc_cnt;
   logic [KEY_W-1:0] acc_key;
   scan_state_t      state;
   logic [FW-1:0]    fcnt;
   logic [KEY_W-1:0] cand;

   logic [3:0]       lows;
   logic [2:0]       col_cnt;
   logic [2:0]       raw_sum;
   logic [1:0]       row_idx;
   logic [1:0]       sum_cnt;
   logic [KEY_W-1:0] sum_key;
   logic             frame_end;
   frame_class_t     cls;
   logic [FW-1:0]    fcnt_inc;

   scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
      .clock (clock),
      .reset (reset),
      .tick  (tick)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row_meta <= 4'b1111;
         row_s    <= 4'b1111;
      end else begin
         row_meta <= row_n;
         row_s    <= row_meta;
      end
   end

   // Low-count saturates at 2: beyond that every frame is MULTI anyway.
   always_comb begin
      lows    = ~row_s;
      col_cnt = '0;
      row_idx = '0;
      for (int r = 0; r < 4; r++) begin
         if (lows[r]) begin
            col_cnt = col_cnt + 3'd1;
            row_idx = 2'(r);
         end
      end
      raw_sum   = {1'b0, acc_cnt} + col_cnt;
      sum_cnt   = (raw_sum >= 3'd2) ? 2'd2 : raw_sum[1:0];
      sum_key   = (col_cnt == 3'd1) ? {row_idx, col_idx} : acc_key;
      frame_end = tick && (col_idx == 2'd3);
      if (sum_cnt == 2'd0) begin
         cls = NONE;
      end else if (sum_cnt == 2'd1) begin
         cls = SINGLE;
      end else begin
         cls = MULTI;
      end
      fcnt_inc = (&fcnt) ? fcnt : fcnt + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col_idx <= '0;
         col_n   <= COL_RESET;
         acc_cnt <= '0;
         acc_key <= '0;
      end else if (tick) begin
         col_idx <= col_idx + 2'd1;
         col_n   <= {col_n[2:0], col_n[3]};
         if (frame_end) begin
            acc_cnt <= '0;
            acc_key <= '0;
         end else begin
            acc_cnt <= sum_cnt;
            acc_key <= sum_key;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         fcnt      <= '0;
         cand      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         digits    <= '0;
      end else begin
         key_valid <= 1'b0;
         if (frame_end) begin
            case (state)
               IDLE: begin
                  if (cls == SINGLE) begin
                     state <= PRESS_WAIT;
                     cand  <= sum_key;
                     fcnt  <= FW'(1);
                  end
               end
               PRESS_WAIT: begin
                  if (cls == SINGLE && sum_key == cand) begin
                     fcnt <= fcnt_inc;
                     if (fcnt_inc == FCNT_DONE) begin
                        state     <= PRESSED;
                        key_code  <= cand;
                        digits    <= {digits[11:0], cand};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                     end
                  end else begin
                     state <= IDLE;
                     fcnt  <= '0;
                  end
               end
               PRESSED: begin
                  if (cls == NONE) begin
                     state <= RELEASE_WAIT;
                     fcnt  <= FW'(1);
                  end
               end
               RELEASE_WAIT: begin
                  if (cls == NONE) begin
                     fcnt <= fcnt_inc;
                     if (fcnt_inc == FCNT_DONE) begin
                        state    <= IDLE;
                        fcnt     <= '0;
                        key_held <= 1'b0;
                     end
                  end else begin
                     state <= PRESSED;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
